// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the AES-128 round controller
package aes_pkg;
    localparam int NR       = 10;
    localparam int BLOCK_W  = 128;
    localparam int RK_IDX_W = 4;
    localparam logic [RK_IDX_W-1:0] NR_IDX = RK_IDX_W'(NR);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } fsm_t;

    // multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
endpackage

// File: rtl/aes_round.sv
// rtl/aes_round.sv - combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey
module aes_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state,
    input  logic [BLOCK_W-1:0] round_key,
    input  logic               final_rnd,
    output logic [BLOCK_W-1:0] next_state
);
    logic [BLOCK_W-1:0] sb;
    logic [BLOCK_W-1:0] sr;
    logic [BLOCK_W-1:0] mc;

    aes_sub_bytes u_sub_bytes (
        .din  (state),
        .dout (sb)
    );

    // byte n sits at row n%4, column n/4; row r rotates left by r columns
    always_comb begin
        sr = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
    end

    always_comb begin
        logic [7:0] b0, b1, b2, b3;
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            b0 = sr[127-32*c -: 8];
            b1 = sr[119-32*c -: 8];
            b2 = sr[111-32*c -: 8];
            b3 = sr[103-32*c -: 8];
            mc[127-32*c -: 8] = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
            mc[119-32*c -: 8] = b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3;
            mc[111-32*c -: 8] = b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3;
            mc[103-32*c -: 8] = xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3);
        end
    end

    assign next_state = (final_rnd ? sr : mc) ^ round_key;
endmodule

// File: rtl/aes_sub_bytes.sv
// rtl/aes_sub_bytes.sv - SubBytes over a full 128-bit block
module aes_sub_bytes
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] din,
    output logic [BLOCK_W-1:0] dout
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // inverse computed as x^254 (maps 0 to 0), then the FIPS-197 affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] s;
        logic [7:0] r;
        s = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        dout = '0;
        for (int n = 0; n < 16; n++) begin
            dout[127-8*n -: 8] = sbox(din[127-8*n -: 8]);
        end
    end
endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES-128 encryptor, one round per cycle
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR_P = NR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BLOCK_W-1:0]  in_data,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [BLOCK_W-1:0]  round_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BLOCK_W-1:0]  out_data,
    output logic                busy
);
    localparam logic [RK_IDX_W-1:0] LAST = RK_IDX_W'(NR_P);

    fsm_t                cur, nxt;
    logic [RK_IDX_W-1:0] cnt, cnt_n;
    logic [BLOCK_W-1:0]  st, st_n;
    logic [BLOCK_W-1:0]  round_out;

    aes_round u_round (
        .state      (st),
        .round_key  (round_key),
        .final_rnd  (cnt == LAST),
        .next_state (round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= ST_IDLE;
            cnt <= '0;
            st  <= '0;
        end else begin
            cur <= nxt;
            cnt <= cnt_n;
            st  <= st_n;
        end
    end

    always_comb begin
        nxt   = cur;
        cnt_n = cnt;
        st_n  = st;
        case (cur)
            ST_IDLE: begin
                if (in_valid) begin
                    st_n  = in_data ^ round_key;
                    cnt_n = RK_IDX_W'(1);
                    nxt   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                st_n = round_out;
                if (cnt == LAST) nxt = ST_DONE;
                else             cnt_n = cnt + RK_IDX_W'(1);
            end
            ST_DONE: begin
                if (out_ready) begin
                    nxt   = ST_IDLE;
                    cnt_n = '0;
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // rk_idx depends only on registered state, so the key store never sees a loop
    assign rk_idx    = (cur == ST_IDLE) ? '0 : cnt;
    assign in_ready  = (cur == ST_IDLE);
    assign busy      = (cur != ST_IDLE);
    assign out_valid = (cur == ST_DONE);
    assign out_data  = st;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - directed self-checking bench for aes_round_ctrl
module tb_aes_round_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] round_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    logic [127:0] rkc [0:10];
    logic [127:0] rkb [0:10];
    logic         ksel;
    logic [7:0]   sbox [0:255];
    int           errors = 0;
    int           checks = 0;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    always #5 clk = ~clk;

    assign round_key = (rk_idx > 4'd10) ? '0 : (ksel ? rkb[rk_idx] : rkc[rk_idx]);

    aes_round_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .round_key (round_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    task automatic expand(input logic [127:0] key, input logic sel);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) begin
            if (sel) rkb[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else     rkc[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    task automatic run_block(input logic [127:0] pt, input logic [127:0] ct, input logic sel,
                             input int hold, input logic garbage);
        @(negedge clk);
        ksel      = sel;
        in_data   = pt;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        check("idle_in_ready", 128'(in_ready), 128'd1);
        check("idle_rk_idx", 128'(rk_idx), 128'd0);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 1; c <= 10; c++) begin
            in_valid = garbage && (c >= 3) && (c <= 5);
            if (garbage) in_data = {$urandom, $urandom, $urandom, $urandom};
            check("round_rk_idx", 128'(rk_idx), 128'(c));
            check("round_out_valid", 128'(out_valid), 128'd0);
            check("round_in_ready", 128'(in_ready), 128'd0);
            check("round_busy", 128'(busy), 128'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("latency_out_valid", 128'(out_valid), 128'd1);
        check("ciphertext", out_data, ct);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_out_valid", 128'(out_valid), 128'd1);
            check("hold_out_data", out_data, ct);
            check("hold_in_ready", 128'(in_ready), 128'd0);
            check("hold_rk_idx", 128'(rk_idx), 128'd10);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("handoff_out_valid", 128'(out_valid), 128'd0);
        check("handoff_in_ready", 128'(in_ready), 128'd1);
        check("handoff_busy", 128'(busy), 128'd0);
    endtask

    initial begin
        int seen;
        int off;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        ksel      = 1'b0;
        build_sbox();
        expand(C1_KEY, 1'b0);
        expand(B_KEY, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 128'(in_ready), 128'd1);
        check("reset_out_valid", 128'(out_valid), 128'd0);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_rk_idx", 128'(rk_idx), 128'd0);
        check("reset_out_data", out_data, 128'd0);
        rst = 1'b0;

        run_block(C1_PT, C1_CT, 1'b0, 0, 1'b0);
        run_block(B_PT, B_CT, 1'b1, 5, 1'b0);
        run_block(C1_PT, C1_CT, 1'b0, 1, 1'b1);

        // abandon a block at round 5
        @(negedge clk);
        ksel     = 1'b0;
        in_data  = C1_PT;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_rk_idx", 128'(rk_idx), 128'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset_in_ready", 128'(in_ready), 128'd1);
        check("midreset_out_valid", 128'(out_valid), 128'd0);
        check("midreset_busy", 128'(busy), 128'd0);
        check("midreset_rk_idx", 128'(rk_idx), 128'd0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        check("midreset_no_out_valid", 128'(seen), 128'd0);
        run_block(C1_PT, C1_CT, 1'b0, 0, 1'b0);

        // back-to-back with both handshakes held high
        @(negedge clk);
        ksel      = 1'b0;
        in_data   = C1_PT;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 36; i++) begin
            off = i % 12;
            check("b2b_rk_idx", 128'(rk_idx), (off == 0) ? 128'd0 : (off == 11) ? 128'd10 : 128'(off));
            check("b2b_in_ready", 128'(in_ready), (off == 0) ? 128'd1 : 128'd0);
            check("b2b_out_valid", 128'(out_valid), (off == 11) ? 128'd1 : 128'd0);
            if (off == 11) check("b2b_ciphertext", out_data, C1_CT);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_end_in_ready", 128'(in_ready), 128'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NR, default 10, meaning number of AES-128 rounds; only 10 is supported.
REQ-002 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 Port rst, input, 1, synchronous active-high reset.
REQ-004 Port in_valid, input, 1, plaintext block offered.
REQ-005 Port in_ready, output, 1, block can be accepted this cycle.
REQ-006 Port in_data, input, 128, plaintext; bits [127:120] = byte 0 (FIPS-197 order).
REQ-007 Port rk_idx, output, 4, index (0..10) of the round key requested this cycle.
REQ-008 Port round_key, input, 128, round key for rk_idx; combinational read, used in the same cycle.
REQ-009 Port out_valid, output, 1, ciphertext available.
REQ-010 Port out_ready, input, 1, consumer accepts ciphertext.
REQ-011 Port out_data, output, 128, ciphertext, same byte order as in_data.
REQ-012 Port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, ROUND and DONE.
REQ-014 IDLE: in_ready=1, rk_idx=0; on in_valid, state register <= in_data XOR round_key, round counter <= 1, go to ROUND.
REQ-015 ROUND: in_ready=0, rk_idx=counter; each cycle, state <= SubBytes -> ShiftRows -> MixColumns -> XOR round_key.
REQ-016 ROUND: MixColumns SHALL be bypassed when counter = NR.
REQ-017 ROUND: counter SHALL increment by 1 each cycle; when counter = NR, the FSM SHALL go to DONE and not increment the counter further.
REQ-018 Latency: with acceptance in cycle k, out_valid SHALL first be high in cycle k+11 (rounds in cycles k+1..k+10).
REQ-019 DONE: out_valid=1 and out_data=state register, both held stable until the cycle in which out_ready=1.
REQ-020 DONE with out_ready=1: the FSM SHALL return to IDLE next cycle and drop out_valid.
REQ-021 A new block SHALL NOT be accepted in the same cycle as ciphertext handoff; the maximum rate is one block per 12 cycles.
REQ-022 in_valid SHALL be ignored outside IDLE; in_data and round_key SHALL be ignored when not sampled.
REQ-023 out_ready SHALL be ignored outside DONE.
REQ-024 rk_idx SHALL be a pure function of FSM state and counter, with no combinational path from any input.
REQ-025 Counter width SHALL be 4 bits; values 11..15 SHALL be unreachable.

Reset
REQ-026 Reset SHALL set FSM=IDLE, counter=0, state register=0, out_valid=0, busy=0, in_ready=1, rk_idx=0.
REQ-027 rst SHALL take priority over every other input in the same cycle.
REQ-028 Reset mid-ROUND or in DONE SHALL abandon the block with no out_valid pulse; IDLE applies in the next cycle.

Structure
REQ-029 Package aes_pkg SHALL hold the FSM state enum, NR=10, block width 128 and rk_idx width 4.
REQ-030 One sub-module, aes_round, SHALL hold the combinational round datapath.
REQ-031 aes_round inputs: state, round_key, final flag; it SHALL instantiate the existing SubBytes block and then apply ShiftRows, optional MixColumns, and AddRoundKey.
REQ-032 aes_round_ctrl SHALL contain only the FSM, the counter and the 128-bit state register.

Verification
REQ-033 FIPS-197 C.1 vector: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, bench supplies round keys per rk_idx -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid at k+11.
REQ-034 FIPS-197 App. B vector: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32.
REQ-035 Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0, rk_idx constant; out_ready=1 -> IDLE next cycle.
REQ-036 in_valid pulsed during ROUND with garbage in_data -> result unchanged vs. REQ-033.
REQ-037 rst asserted at round 5 -> next cycle IDLE, in_ready=1, out_valid never asserted; subsequent C.1 run correct.
REQ-038 Back-to-back: in_valid held high with out_ready=1 -> blocks accepted every 12 cycles; rk_idx sequence per block is 0,1,...,10.
